// File: rtl/slave_b_channel_resp_buffer_pkg.sv
// Shared types for the AXI slave write-response path.
//   bresp_e        : AXI BRESP codes
//   b_resp_entry_t : {id, resp} queue entry at the default ID width
//   grant_e        : which internal source won the last arbitration
package axi_slave_package;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } bresp_e;

    localparam int unsigned DEFAULT_ID_WIDTH = 4;

    typedef struct packed {
        logic [DEFAULT_ID_WIDTH-1:0] id;
        bresp_e                      resp;
    } b_resp_entry_t;

    typedef enum logic {
        ERR  = 1'b0,
        POST = 1'b1
    } grant_e;

endpackage

// File: rtl/slave_b_channel_resp_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO for write-response entries.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and entry (ignored while full)
//   pop_i             : read request (ignored while empty)
//   rdata_o           : head entry, valid whenever empty_o is low
//   full_o, empty_o   : occupancy flags from registered pointers
//   count_o           : occupancy, 0..DEPTH
module slave_b_resp_fifo
    import axi_slave_package::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = b_resp_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  entry_t                 wdata_i,
    input  logic                   pop_i,
    output entry_t                 rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        count_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed between the pointers.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/slave_b_channel_resp_buffer.sv
// AXI4 B-channel transmitter for the slave side of the PCIe TL AXI interface.
// Two internal sources (error responses, posted-write completions) are
// round-robin arbitrated, queued in order and presented on BVALID/BID/BRESP.
// Ports:
//   ACLK, ARESET                        : clock, synchronous active-high reset
//   err_valid/err_ready/err_id/err_resp : error response request
//   post_valid/post_ready/post_id/post_resp : posted completion request
//   BVALID/BREADY/BID/BRESP             : AXI write response channel
//   count                               : queue occupancy
module slave_b_channel_resp_buffer
    import axi_slave_package::*;
#(
    parameter int unsigned ID_WIDTH = DEFAULT_ID_WIDTH,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   err_valid,
    output logic                   err_ready,
    input  logic [ID_WIDTH-1:0]    err_id,
    input  logic [1:0]             err_resp,
    input  logic                   post_valid,
    output logic                   post_ready,
    input  logic [ID_WIDTH-1:0]    post_id,
    input  logic [1:0]             post_resp,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [ID_WIDTH-1:0]    BID,
    output logic [1:0]             BRESP,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        bresp_e              resp;
    } entry_t;

    grant_e last_grant_q, last_grant_d;
    logic   grant_err;
    logic   grant_post;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t fifo_wdata;
    entry_t fifo_head;

    always_comb begin
        // Posted wins when alone, or on contention if error had the last turn.
        grant_post   = post_valid && (!err_valid || (last_grant_q == ERR));
        grant_err    = err_valid && !grant_post;
        // Full is registered state: a same-cycle pop never frees room for a push.
        err_ready    = grant_err && !fifo_full && !ARESET;
        post_ready   = grant_post && !fifo_full && !ARESET;
        fifo_push    = err_ready || post_ready;
        fifo_wdata   = post_ready ? entry_t'{id: post_id, resp: bresp_e'(post_resp)}
                                  : entry_t'{id: err_id, resp: bresp_e'(err_resp)};
        last_grant_d = last_grant_q;
        if (post_ready) begin
            last_grant_d = POST;
        end else if (err_ready) begin
            last_grant_d = ERR;
        end
        BVALID   = !fifo_empty;
        fifo_pop = BVALID && BREADY;
        BID      = fifo_empty ? '0 : fifo_head.id;
        BRESP    = fifo_empty ? 2'b00 : fifo_head.resp;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            last_grant_q <= ERR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    slave_b_resp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_slave_b_channel_resp_buffer.sv
module tb_slave_b_channel_resp_buffer;

    localparam int OK  = 0;
    localparam int SLV = 2;
    localparam int DEC = 3;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       err_valid = 1'b0;
    logic       err_ready;
    logic [3:0] err_id = '0;
    logic [1:0] err_resp = '0;
    logic       post_valid = 1'b0;
    logic       post_ready;
    logic [3:0] post_id = '0;
    logic [1:0] post_resp = '0;
    logic       BVALID;
    logic       BREADY = 1'b0;
    logic [3:0] BID;
    logic [1:0] BRESP;
    logic [3:0] count;

    typedef struct {
        int id;
        int resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 ACLK = ~ACLK;

    slave_b_channel_resp_buffer #(
        .ID_WIDTH (4),
        .DEPTH    (8)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .err_id     (err_id),
        .err_resp   (err_resp),
        .post_valid (post_valid),
        .post_ready (post_ready),
        .post_id    (post_id),
        .post_resp  (post_resp),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .BID        (BID),
        .BRESP      (BRESP),
        .count      (count)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic exp_push(input int id, input int resp);
        exp_t e;
        e.id   = id;
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs on the falling edge, return just before the rising edge.
    task automatic drive(input logic rst, input logic ev, input int eid, input int eresp,
                         input logic pv, input int pid, input int presp, input logic br);
        @(negedge ACLK);
        ARESET     = rst;
        err_valid  = ev;
        err_id     = 4'(eid);
        err_resp   = 2'(eresp);
        post_valid = pv;
        post_id    = 4'(pid);
        post_resp  = 2'(presp);
        BREADY     = br;
        #4;
    endtask

    task automatic idle(input logic br);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, br);
    endtask

    // Scoreboard monitor: every B handshake must match the next expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            #4;
            if (BVALID && BREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got BID %0d expected no response", BID);
                end else begin
                    e = exp_q.pop_front();
                    chk("b_id", int'(BID), e.id);
                    chk("b_resp", int'(BRESP), e.resp);
                end
            end
        end
    end

    initial begin
        // Reset held with an error request pending: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5, SLV, 1'b0, 0, 0, 1'b0);
            chk("rst_err_ready", int'(err_ready), 0);
            chk("rst_bvalid", int'(BVALID), 0);
            chk("rst_count", int'(count), 0);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk("idle_bvalid", int'(BVALID), 0);
            chk("idle_bid", int'(BID), 0);
            chk("idle_bresp", int'(BRESP), 0);
            chk("idle_count", int'(count), 0);
            chk("idle_post_ready", int'(post_ready), 0);
        end

        // Single posted completion: one-cycle latency.
        drive(1'b0, 1'b0, 0, 0, 1'b1, 3, OK, 1'b1);
        exp_push(3, OK);
        chk("single_post_ready", int'(post_ready), 1);
        chk("single_bvalid_c0", int'(BVALID), 0);
        idle(1'b1);
        chk("single_bvalid_c1", int'(BVALID), 1);
        chk("single_count_c1", int'(count), 1);
        idle(1'b1);
        chk("single_count_c2", int'(count), 0);
        chk("single_bvalid_c2", int'(BVALID), 0);

        // Reset restores last_grant to ERR so posted wins the first contention.
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1, SLV, 1'b1, 2, OK, 1'b1);
            chk("cont_post_ready", int'(post_ready), (i % 2 == 0) ? 1 : 0);
            chk("cont_err_ready", int'(err_ready), (i % 2 == 0) ? 0 : 1);
            chk("cont_count", int'(count), (i == 0) ? 0 : 1);
            if (i % 2 == 0) exp_push(2, OK);
            else            exp_push(1, SLV);
        end
        idle(1'b1);
        idle(1'b1);
        chk("cont_drained", int'(count), 0);

        // Back-pressure: fill to 8 with BREADY low, head stays id 0 / OKAY.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b1, i, OK, 1'b0);
            exp_push(i, OK);
            chk("bp_post_ready", int'(post_ready), 1);
            chk("bp_count", int'(count), i);
            chk("bp_bvalid", int'(BVALID), (i == 0) ? 0 : 1);
            chk("bp_bid_stable", int'(BID), 0);
            chk("bp_bresp_stable", int'(BRESP), OK);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b1, 8, OK, 1'b0);
        chk("bp_ninth_ready", int'(post_ready), 0);
        chk("bp_full_count", int'(count), 8);
        chk("bp_full_bid", int'(BID), 0);

        // Full with pop in the same cycle: no push-through.
        drive(1'b0, 1'b0, 0, 0, 1'b1, 8, OK, 1'b1);
        chk("fullpop_post_ready", int'(post_ready), 0);
        chk("fullpop_count", int'(count), 8);
        drive(1'b0, 1'b0, 0, 0, 1'b1, 8, OK, 1'b1);
        exp_push(8, OK);
        chk("fullpop_next_ready", int'(post_ready), 1);
        chk("fullpop_next_count", int'(count), 7);
        idle(1'b1);
        chk("fullpop_count_held", int'(count), 7);
        for (int i = 0; i < 7; i++) idle(1'b1);
        chk("fullpop_drained", int'(count), 0);

        // Reset mid-operation discards queued entries.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 10 + i, DEC, 1'b0, 0, 0, 1'b0);
            chk("mid_err_ready", int'(err_ready), 1);
            chk("mid_count", int'(count), i);
        end
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        chk("mid_rst_count_before", int'(count), 5);
        idle(1'b0);
        chk("mid_after_bvalid", int'(BVALID), 0);
        chk("mid_after_count", int'(count), 0);
        drive(1'b0, 1'b0, 0, 0, 1'b1, 9, OK, 1'b1);
        exp_push(9, OK);
        chk("mid_new_ready", int'(post_ready), 1);
        idle(1'b1);
        chk("mid_new_bid", int'(BID), 9);
        idle(1'b1);
        idle(1'b1);
        chk("final_count", int'(count), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
